booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_mult_seq.sv | 126 ++++++++++++
 tb/tb_booth_mult_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: 32x32 signed, one iteration per clock.
// Product bits [31:0] appear on data_result and bits [63:31] on ovf_bits
// one cycle after the 32nd iteration, strobed by data_resultRDY.
module booth_mult_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic [32:0] ovf_bits,
  output logic        mcand_msb,
  output logic        mplier_msb,
  output logic        busy
);

  localparam int unsigned W     = 32;
  localparam int unsigned AW    = W + 1;
  localparam int unsigned CW    = 6;
  localparam int unsigned LAST  = W - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [AW-1:0]   m_q, m_d;
  logic [W-1:0]    q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mcand_msb_q, mcand_msb_d;
  logic            mplier_msb_q, mplier_msb_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   sum_c;

  // Booth recode of {Q[0], q_m1}: add, subtract or pass the partial product.
  always_comb begin
    sum_c = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum_c = a_q + m_q;
      2'b10:   sum_c = a_q - m_q;
      default: sum_c = a_q;
    endcase
  end

  // Next-state logic: a start pulse reloads from any state, otherwise iterate.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    m_d          = m_q;
    q_d          = q_q;
    qm1_d        = qm1_q;
    cnt_d        = cnt_q;
    mcand_msb_d  = mcand_msb_q;
    mplier_msb_d = mplier_msb_q;

    if (ctrl_MULT) begin
      m_d          = {data_operandA[W-1], data_operandA};
      q_d          = data_operandB;
      a_d          = '0;
      qm1_d        = 1'b0;
      cnt_d        = '0;
      mcand_msb_d  = data_operandA[W-1];
      mplier_msb_d = data_operandB[W-1];
      state_d      = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          // Arithmetic right shift of {A, Q, q_m1} applied to the updated A.
          a_d   = {sum_c[AW-1], sum_c[AW-1:1]};
          q_d   = {sum_c[0], q_q[W-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(LAST)) begin
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    rdy_d  = (state_d == S_DONE);
    busy_d = (state_d == S_RUN);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      m_q          <= '0;
      q_q          <= '0;
      qm1_q        <= 1'b0;
      cnt_q        <= '0;
      mcand_msb_q  <= 1'b0;
      mplier_msb_q <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      m_q          <= m_d;
      q_q          <= q_d;
      qm1_q        <= qm1_d;
      cnt_q        <= cnt_d;
      mcand_msb_q  <= mcand_msb_d;
      mplier_msb_q <= mplier_msb_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
    end
  end

  assign data_result    = q_q;
  assign ovf_bits       = {a_q[W-1:0], q_q[W-1]};
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
  assign mcand_msb      = mcand_msb_q;
  assign mplier_msb     = mplier_msb_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed operand pairs, expected products queued
// at issue time and checked by a monitor whenever the ready strobe appears.
module tb_booth_mult_seq;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic [32:0] ovf_bits;
  logic        mcand_msb;
  logic        mplier_msb;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic [32:0] ovf;
    logic        ma;
    logic        mb;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   cyc;

  booth_mult_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .ovf_bits       (ovf_bits),
    .mcand_msb      (mcand_msb),
    .mplier_msb     (mplier_msb),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running cycle count used to check ready latency.
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one start pulse; optionally queue the expected result.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit track,
                       input logic [31:0] er, input logic [32:0] eo,
                       input logic ema, input logic emb);
    exp_t e;
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    if (track) begin
      e.res = er; e.ovf = eo; e.ma = ema; e.mb = emb; e.cyc = cyc + 33;
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int busy_cnt;
    exp_t e;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    data_operandA = 32'h1234_5678;
    data_operandB = 32'h9ABC_DEF0;

    // Scoreboard monitor: every ready strobe must match the oldest queued entry.
    fork
      forever begin
        @(negedge clock);
        if (data_resultRDY === 1'b1) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rdy actual=1 required=0 at cycle %0d", cyc);
          end else begin
            e = sb.pop_front();
            chk("result", 64'(data_result), 64'(e.res));
            chk("ovf_bits", 64'(ovf_bits), 64'(e.ovf));
            chk("msbs", 64'({mcand_msb, mplier_msb}), 64'({e.ma, e.mb}));
            chk("rdy_cycle", 64'(cyc), 64'(e.cyc));
            chk("busy_at_rdy", 64'(busy), 64'd0);
          end
        end
      end
    join_none

    // Reset values while reset is held.
    #12;
    chk("rst_result", 64'(data_result), 64'd0);
    chk("rst_ovf", 64'(ovf_bits), 64'd0);
    chk("rst_rdy_busy", 64'({data_resultRDY, busy}), 64'd0);
    chk("rst_msbs", 64'({mcand_msb, mplier_msb}), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 3 x 5 with busy width measured over the whole operation.
    issue(32'd3, 32'd5, 1'b1, 32'h0000_000F, 33'h0, 1'b0, 1'b0);
    busy_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
    end
    chk("busy_width", 64'(busy_cnt), 64'd32);
    drain();
    chk("hold_result", 64'(data_result), 64'h0000_000F);

    // Back-to-back: each next start lands in the DONE cycle of the previous.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 33'h0, 1'b1, 1'b1);
    repeat (31) @(negedge clock);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 33'h0_0000_0001, 1'b1, 1'b1);
    repeat (31) @(negedge clock);
    issue(32'h4000_0000, 32'd4, 1'b1, 32'h0, 33'h0_0000_0002, 1'b0, 1'b0);
    drain();
    issue(32'hFFFF_FFF9, 32'd3, 1'b1, 32'hFFFF_FFEB, 33'h1_FFFF_FFFF, 1'b1, 1'b0);
    drain();
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 33'h0_8000_0000, 1'b1, 1'b1);
    drain();
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h0000_0001, 33'h0_7FFF_FFFE, 1'b0, 1'b0);
    drain();
    repeat (3) @(negedge clock);
    chk("hold_ovf", 64'(ovf_bits), 64'h0_7FFF_FFFE);

    // Restart 10 cycles into 3 x 5 with 6 x 7: only the second completes.
    issue(32'd3, 32'd5, 1'b0, 32'h0, 33'h0, 1'b0, 1'b0);
    repeat (8) @(negedge clock);
    issue(32'd6, 32'd7, 1'b1, 32'h0000_002A, 33'h0, 1'b0, 1'b0);
    drain();

    // Asynchronous reset at iteration 16, then a start on the release edge.
    issue(32'hFFFF_FFF9, 32'd3, 1'b0, 32'h0, 33'h0, 1'b0, 1'b0);
    repeat (16) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_result", 64'(data_result), 64'd0);
    chk("arst_ovf", 64'(ovf_bits), 64'd0);
    chk("arst_rdy_busy_msbs", 64'({data_resultRDY, busy, mcand_msb, mplier_msb}), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("idle_after_reset", 64'({busy, data_resultRDY}), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'hFFFF_FFF9;
    data_operandB = 32'd3;
    e.res = 32'hFFFF_FFEB; e.ovf = 33'h1_FFFF_FFFF; e.ma = 1'b1; e.mb = 1'b0; e.cyc = cyc + 33;
    sb.push_back(e);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    drain();
    repeat (5) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
